// File: rtl/bus_pkg.sv
// Shared types and constants for the 2-master / 3-slave serial bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {IDLE, HDR, CONN, WAIT_REL} arb_state_t;

  localparam int N_MASTERS = 2;
  localparam int N_SLAVES  = 3;
  localparam int ID_W      = 2;
  localparam int ADDR_W    = 15;

endpackage

// File: rtl/bus_arbiter_2m3s_counter.sv
// Free-running up-counter with synchronous clear, used for header bits and CONN timeout.
module bus_arbiter_2m3s_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter_2m3s.sv
// Round-robin arbiter for 2 masters plus slave-ID header decoder and line router for 3 slaves.
module bus_arbiter_2m3s #(
  parameter int N_SLAVES = 3,
  parameter int ID_W     = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          M_BREQ,
  input  logic [1:0]          M_RW,
  input  logic [1:0]          M_BUS_OUT,
  output logic [1:0]          M_GRANT,
  output logic [1:0]          M_ACK,
  output logic [1:0]          M_READY,
  output logic [1:0]          M_SBSY,
  output logic [1:0]          M_BUS_IN,
  output logic [1:0]          M_ERR,
  output logic [N_SLAVES-1:0] S_AD_SEL,
  input  logic [N_SLAVES-1:0] S_ACK,
  input  logic [N_SLAVES-1:0] S_READY,
  input  logic [N_SLAVES-1:0] S_SBSY,
  input  logic [N_SLAVES-1:0] S_BUS_IN,
  output logic                B_RW,
  output logic                B_BUS_OUT
);
  import bus_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t          state_reg;
  logic [1:0]          grant_reg;
  logic                g_reg;
  logic                prio_reg;
  logic [ID_W-1:0]     id_reg;
  logic [N_SLAVES-1:0] sel_reg;
  logic [1:0]          err_reg;
  logic [CW-1:0]       cnt;
  logic                cnt_clr;
  logic [ID_W-1:0]     id_next;
  logic                hdr_done;
  logic                tmo;
  logic                winner;
  logic                ack_sel, rdy_sel, sbsy_sel, bin_sel;

  // One counter serves both phases: cleared while idle and again on entering CONN.
  assign cnt_clr  = (state_reg == IDLE) || ((state_reg == HDR) && hdr_done);
  assign hdr_done = (cnt == CW'(ID_W - 1));
  assign tmo      = (cnt == CW'(TIMEOUT - 1));
  assign id_next  = id_reg | (ID_W'(M_BUS_OUT[g_reg]) << cnt);
  assign winner   = (&M_BREQ) ? prio_reg : M_BREQ[1];

  bus_arbiter_2m3s_counter #(.WIDTH(CW)) u_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (cnt_clr),
    .en    (1'b1),
    .count (cnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      g_reg     <= 1'b0;
      prio_reg  <= 1'b0;
      id_reg    <= '0;
      sel_reg   <= '0;
      err_reg   <= '0;
    end else begin
      err_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (|M_BREQ) begin
            grant_reg <= 2'b01 << winner;
            g_reg     <= winner;
            prio_reg  <= ~winner;
            id_reg    <= '0;
            state_reg <= HDR;
          end
        end
        HDR: begin
          if (!M_BREQ[g_reg]) begin
            grant_reg <= '0;
            state_reg <= IDLE;
          end else begin
            id_reg <= id_next;
            if (hdr_done) begin
              if (int'(id_next) < N_SLAVES) begin
                sel_reg   <= N_SLAVES'(1) << id_next;
                state_reg <= CONN;
              end else begin
                err_reg[g_reg] <= 1'b1;
                state_reg      <= WAIT_REL;
              end
            end
          end
        end
        CONN: begin
          if (!M_BREQ[g_reg]) begin
            sel_reg   <= '0;
            grant_reg <= '0;
            state_reg <= IDLE;
          end else if (tmo) begin
            sel_reg        <= '0;
            err_reg[g_reg] <= 1'b1;
            state_reg      <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!M_BREQ[g_reg]) begin
            grant_reg <= '0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // sel_reg is zero outside CONN, so the return path is silent in every other state.
  assign ack_sel  = |(S_ACK    & sel_reg);
  assign rdy_sel  = |(S_READY  & sel_reg);
  assign sbsy_sel = |(S_SBSY   & sel_reg);
  assign bin_sel  = |(S_BUS_IN & sel_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign M_ACK[gi]    = grant_reg[gi] & ack_sel;
      assign M_READY[gi]  = grant_reg[gi] & rdy_sel;
      assign M_SBSY[gi]   = grant_reg[gi] & sbsy_sel;
      assign M_BUS_IN[gi] = grant_reg[gi] & bin_sel;
    end
  endgenerate

  assign M_GRANT   = grant_reg;
  assign M_ERR     = err_reg;
  assign S_AD_SEL  = sel_reg;
  assign B_RW      = (state_reg == CONN) & M_RW[g_reg];
  assign B_BUS_OUT = (state_reg == CONN) & M_BUS_OUT[g_reg];

endmodule

// File: tb/tb_bus_arbiter_2m3s.sv
// Directed + randomized bench for bus_arbiter_2m3s against a transaction-level reference model.
module tb_bus_arbiter_2m3s;

  localparam int TMO = 16;
  localparam int NS  = 3;
  localparam int IDW = 2;

  logic          CLK, RST;
  logic [1:0]    M_BREQ, M_RW, M_BUS_OUT;
  logic [1:0]    M_GRANT, M_ACK, M_READY, M_SBSY, M_BUS_IN, M_ERR;
  logic [NS-1:0] S_AD_SEL, S_ACK, S_READY, S_SBSY, S_BUS_IN;
  logic          B_RW, B_BUS_OUT;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter_2m3s #(.N_SLAVES(NS), .ID_W(IDW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .M_BREQ(M_BREQ), .M_RW(M_RW), .M_BUS_OUT(M_BUS_OUT),
    .M_GRANT(M_GRANT), .M_ACK(M_ACK), .M_READY(M_READY), .M_SBSY(M_SBSY),
    .M_BUS_IN(M_BUS_IN), .M_ERR(M_ERR),
    .S_AD_SEL(S_AD_SEL), .S_ACK(S_ACK), .S_READY(S_READY), .S_SBSY(S_SBSY),
    .S_BUS_IN(S_BUS_IN),
    .B_RW(B_RW), .B_BUS_OUT(B_BUS_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: who owns the bus, which slave is linked, how far along we are.
  typedef enum {FREE, HEADER, LINKED, HOLD} phase_t;
  phase_t     m_phase;
  int         m_owner, m_slave, m_last, m_bits, m_id, m_cycles;
  logic [1:0] m_err;

  task automatic model_reset();
    m_phase = FREE; m_owner = -1; m_slave = -1; m_last = 1; m_err = 2'b00;
    m_bits = 0; m_id = 0; m_cycles = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    m_err = 2'b00;
    case (m_phase)
      FREE: if (M_BREQ != 2'b00) begin
        if (M_BREQ == 2'b11) m_owner = 1 - m_last;
        else                 m_owner = M_BREQ[1] ? 1 : 0;
        m_last = m_owner; m_bits = 0; m_id = 0; m_phase = HEADER;
      end
      HEADER: if (!M_BREQ[m_owner]) begin
        m_owner = -1; m_phase = FREE;
      end else begin
        m_id = m_id + (int'(M_BUS_OUT[m_owner]) << m_bits);
        m_bits++;
        if (m_bits == IDW) begin
          if (m_id < NS) begin m_slave = m_id; m_cycles = 0; m_phase = LINKED; end
          else begin m_err[m_owner] = 1'b1; m_phase = HOLD; end
        end
      end
      LINKED: if (!M_BREQ[m_owner]) begin
        m_owner = -1; m_slave = -1; m_phase = FREE;
      end else begin
        m_cycles++;
        if (m_cycles == TMO) begin m_slave = -1; m_err[m_owner] = 1'b1; m_phase = HOLD; end
      end
      HOLD: if (!M_BREQ[m_owner]) begin m_owner = -1; m_phase = FREE; end
      default: m_phase = FREE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [1:0]    eg, eack, erdy, esb, ebin;
    logic [NS-1:0] es;
    logic          erw, ebo;
    eg = 2'b00; es = '0; eack = 2'b00; erdy = 2'b00; esb = 2'b00; ebin = 2'b00;
    erw = 1'b0; ebo = 1'b0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (m_slave >= 0) begin
      es[m_slave]     = 1'b1;
      eack[m_owner]   = S_ACK[m_slave];
      erdy[m_owner]   = S_READY[m_slave];
      esb[m_owner]    = S_SBSY[m_slave];
      ebin[m_owner]   = S_BUS_IN[m_slave];
      erw             = M_RW[m_owner];
      ebo             = M_BUS_OUT[m_owner];
    end
    chk("grant", 16'(M_GRANT), 16'(eg));
    chk("ad_sel", 16'(S_AD_SEL), 16'(es));
    chk("err", 16'(M_ERR), 16'(m_err));
    chk("ret_lines", 16'({M_ACK, M_READY, M_SBSY, M_BUS_IN}), 16'({eack, erdy, esb, ebin}));
    chk("fwd_lines", 16'({B_RW, B_BUS_OUT}), 16'({erw, ebo}));
    $display("t=%0t breq=%b grant=%b sel=%b err=%b", $time, M_BREQ, M_GRANT, S_AD_SEL, M_ERR);
  endtask

  task automatic cyc();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_model();
  endtask

  task automatic rand_lines();
    M_RW = 2'($urandom); M_BUS_OUT = 2'($urandom);
    S_ACK = NS'($urandom); S_READY = NS'($urandom); S_SBSY = NS'($urandom);
    S_BUS_IN = NS'($urandom);
  endtask

  // Sends the ID header LSB first for master m; E0 already taken.
  task automatic send_hdr(input int m, input logic [1:0] id);
    for (int k = 0; k < IDW; k++) begin
      rand_lines();
      M_BUS_OUT[m] = id[k];
      cyc();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 16'({M_GRANT, M_ACK, M_READY, M_SBSY, M_BUS_IN, M_ERR}), 16'h0);
    chk({tag, "_sel"}, 16'({S_AD_SEL, B_RW, B_BUS_OUT}), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; M_BREQ = 2'b00; M_RW = 2'b00; M_BUS_OUT = 2'b00;
    S_ACK = '0; S_READY = '0; S_SBSY = '0; S_BUS_IN = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;

    // 1: M0 addresses slave 1, pass-through, release
    M_BREQ = 2'b01; cyc();
    chk("t1_grant_e0", 16'(M_GRANT), 16'h1);
    send_hdr(0, 2'd1);
    chk("t1_sel_e2", 16'(S_AD_SEL), 16'h2);
    M_BUS_OUT = 2'b01; S_ACK = 3'b010; #1;
    chk("t1_bout", 16'(B_BUS_OUT), 16'h1);
    chk("t1_ack", 16'(M_ACK), 16'h1);
    repeat (4) begin rand_lines(); cyc(); end
    M_BREQ = 2'b00; cyc();
    chk("t1_release", 16'({M_GRANT, S_AD_SEL}), 16'h0);

    // 2: simultaneous requests after reset, round robin
    @(negedge CLK); #2 RST = 1'b1; model_reset(); #1;
    chk_all_zero("t2_reset");
    @(negedge CLK); RST = 1'b0;
    M_BREQ = 2'b11; cyc();
    chk("t2_first_m0", 16'(M_GRANT), 16'h1);
    send_hdr(0, 2'd0);
    repeat (3) begin rand_lines(); cyc(); end
    M_BREQ = 2'b10; cyc();
    chk("t2_idle_gap", 16'(M_GRANT), 16'h0);
    cyc();
    chk("t2_then_m1", 16'(M_GRANT), 16'h2);
    send_hdr(1, 2'd2);
    chk("t2_m1_sel", 16'(S_AD_SEL), 16'h4);
    M_BREQ = 2'b11; repeat (2) begin rand_lines(); cyc(); end
    M_BREQ = 2'b01; cyc();
    M_BREQ = 2'b11; cyc();
    chk("t2_back_to_m0", 16'(M_GRANT), 16'h1);
    M_BREQ = 2'b00; cyc(); cyc();

    // 3: M1 sends invalid ID 3
    M_BREQ = 2'b10; cyc();
    send_hdr(1, 2'd3);
    chk("t3_err", 16'({M_ERR, S_AD_SEL}), 16'({2'b10, 3'b000}));
    cyc();
    chk("t3_err_gone", 16'({M_ERR, M_GRANT}), 16'({2'b00, 2'b10}));
    repeat (3) begin rand_lines(); cyc(); end
    M_BREQ = 2'b00; cyc();
    chk("t3_release", 16'(M_GRANT), 16'h0);

    // 4: M0 aborts after one header bit
    M_BREQ = 2'b01; cyc();
    M_BUS_OUT = 2'b01; cyc();
    M_BREQ = 2'b00; cyc();
    chk("t4_abort", 16'({M_GRANT, S_AD_SEL, M_ERR}), 16'h0);
    cyc();

    // 5: timeout while M1 waits
    M_BREQ = 2'b01; cyc();
    send_hdr(0, 2'd2);
    M_BREQ = 2'b11;
    repeat (TMO - 1) begin rand_lines(); cyc(); end
    chk("t5_still_conn", 16'(S_AD_SEL), 16'h4);
    cyc();
    chk("t5_timeout", 16'({S_AD_SEL, M_ERR}), 16'({3'b000, 2'b01}));
    repeat (3) cyc();
    chk("t5_m1_blocked", 16'(M_GRANT), 16'h1);
    M_BREQ = 2'b10; cyc(); cyc();
    chk("t5_m1_granted", 16'(M_GRANT), 16'h2);
    M_BREQ = 2'b00; cyc(); cyc();

    // 6: reset during a slave write
    M_BREQ = 2'b10; M_RW = 2'b10; cyc();
    send_hdr(1, 2'd1);
    M_RW = 2'b10; cyc(); cyc();
    #2 RST = 1'b1; model_reset(); #1;
    chk_all_zero("t6_async_reset");
    @(negedge CLK); RST = 1'b0;
    M_BREQ = 2'b11; cyc();
    chk("t6_m0_first", 16'(M_GRANT), 16'h1);
    M_BREQ = 2'b00; cyc(); cyc();

    // Random traffic: requests held for random stretches
    for (int i = 0; i < 400; i++) begin
      rand_lines();
      for (int m = 0; m < 2; m++)
        if ($urandom_range(0, 11) == 0) M_BREQ[m] = ~M_BREQ[m];
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
